// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, icache frame layout, FSM states, default set count.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS = 16;

  // Tag field sized for a word address; unused upper bits are zero for larger SETS.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    word_t       data;
  } icache_frame_t;

  typedef enum logic {IDLE, FETCH} icache_state_t;
endpackage

// File: rtl/icache_frames.sv
// Direct-mapped frame storage: combinational read port, synchronous write port.
module icache_frames
  import cpu_types_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     rd_idx,
  output icache_frame_t        rd_frame,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  icache_frame_t        wr_frame
);
  logic [SETS-1:0] valid;
  logic [29:0]     tag_mem  [SETS];
  word_t           data_mem [SETS];

  // Only valid bits are reset; tag/data contents are don't-care until filled.
  always_ff @(posedge clk) begin
    if (rst)        valid <= '0;
    else if (wr_en) valid[wr_idx] <= wr_frame.valid;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_frame.tag;
      data_mem[wr_idx] <= wr_frame.data;
    end
  end

  always_comb begin
    rd_frame       = '0;
    rd_frame.valid = valid[rd_idx];
    rd_frame.tag   = tag_mem[rd_idx];
    rd_frame.data  = data_mem[rd_idx];
  end
endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with IDLE/FETCH miss FSM.
// Define ICACHE_STATS_EN to add hit_count/miss_count outputs.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IDX_W = $clog2(SETS);

  icache_state_t    state;
  word_t            miss_addr;
  icache_frame_t    rd_frame, wr_frame;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             hit, miss, wr_en;
  logic             unused_offset;

  assign unused_offset = ^imemaddr[1:0];
  assign rd_idx = imemaddr[IDX_W+1:2];
  assign wr_idx = miss_addr[IDX_W+1:2];

  assign hit  = (state == IDLE) && imemREN && rd_frame.valid &&
                (rd_frame.tag == 30'(imemaddr[31:IDX_W+2]));
  assign miss = (state == IDLE) && imemREN && !hit;

  assign ihit     = hit;
  assign imemload = hit ? rd_frame.data : '0;
  assign iREN     = (state == FETCH);
  assign iaddr    = iREN ? miss_addr : '0;

  // A reset landing on the final fill cycle must not commit the frame.
  assign wr_en = (state == FETCH) && !iwait && !RST;

  always_comb begin
    wr_frame       = '0;
    wr_frame.valid = 1'b1;
    wr_frame.tag   = 30'(miss_addr[31:IDX_W+2]);
    wr_frame.data  = iload;
  end

  icache_frames #(.SETS(SETS), .IDX_W(IDX_W)) u_frames (
    .clk      (CLK),
    .rst      (RST),
    .rd_idx   (rd_idx),
    .rd_frame (rd_frame),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_frame (wr_frame)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      miss_addr <= '0;
    end else begin
      case (state)
        IDLE: if (miss) begin
          miss_addr <= {imemaddr[31:2], 2'b00};
          state     <= FETCH;
        end
        FETCH: if (!iwait) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)  hit_count  <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: reference cache model predicts hit/miss, queue holds expected words.
module tb_icache;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic        mvalid [16];
  logic [25:0] mtag   [16];

  always #5 CLK = ~CLK;

  icache #(.SETS(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C010004;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  // One complete fetch starting right after a posedge; model decides hit or miss path.
  task automatic do_fetch(input logic [31:0] a, input int nwait);
    logic [31:0] wa, exp;
    logic [3:0]  idx;
    logic        mh;
    wa  = {a[31:2], 2'b00};
    idx = wa[5:2];
    mh  = mvalid[idx] && (mtag[idx] == wa[31:6]);
    exp_q.push_back(mem_word(wa));
    imemREN = 1'b1; imemaddr = a; iwait = 1'b1;
    @(negedge CLK);
    if (mh) begin
      exp = exp_q.pop_front();
      vectors++;
      if (ihit !== 1'b1 || imemload !== exp) begin
        miscompares++;
        $display("FAIL hit_data addr=%h: ihit=%b imemload=%h, want ihit=1 imemload=%h", a, ihit, imemload, exp);
      end
      vectors++;
      if (iREN !== 1'b0) begin
        miscompares++;
        $display("FAIL hit_no_req addr=%h: iREN=%b, want 0", a, iREN);
      end
    end else begin
      vectors++;
      if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0) begin
        miscompares++;
        $display("FAIL miss_idle addr=%h: ihit=%b imemload=%h iREN=%b, want 0/0/0", a, ihit, imemload, iREN);
      end
      for (int k = 0; k <= nwait; k++) begin
        step();
        iwait = (k < nwait);
        iload = (k < nwait) ? 32'hDEAD_BEEF : mem_word(wa);
        @(negedge CLK);
        vectors++;
        if (iREN !== 1'b1 || iaddr !== wa || ihit !== 1'b0) begin
          miscompares++;
          $display("FAIL fetch_req addr=%h cyc=%0d: iREN=%b iaddr=%h ihit=%b, want 1/%h/0", a, k, iREN, iaddr, ihit, wa);
        end
      end
      step();
      iwait = 1'b1; iload = '0;
      @(negedge CLK);
      exp = exp_q.pop_front();
      vectors++;
      if (ihit !== 1'b1 || imemload !== exp || iREN !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_hit addr=%h: ihit=%b imemload=%h iREN=%b, want 1/%h/0", a, ihit, imemload, iREN, exp);
      end
      mvalid[idx] = 1'b1;
      mtag[idx]   = wa[31:6];
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; imemREN = 1'b0; iwait = 1'b1;
    step(); step();
    RST = 1'b0;
    model_clear();
    @(negedge CLK);
    vectors++;
    if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0 || iaddr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: ihit=%b imemload=%h iREN=%b iaddr=%h, want all 0", ihit, imemload, iREN, iaddr);
    end
`ifdef ICACHE_STATS_EN
    vectors++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_stats: hit=%0d miss=%0d, want 0/0", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_cold_miss();
    step(); do_fetch(32'h40, 3);
  endtask

  task automatic test_repeat_hit();
    step(); do_fetch(32'h40, 0);
    step(); do_fetch(32'h43, 0);
  endtask

  task automatic test_stats();
`ifdef ICACHE_STATS_EN
    step(); imemREN = 1'b0;
    @(negedge CLK);
    vectors++;
    if (miss_count !== 32'd1 || hit_count !== 32'd3) begin
      miscompares++;
      $display("FAIL stats: miss=%0d hit=%0d, want 1/3", miss_count, hit_count);
    end
`endif
  endtask

  task automatic test_idle_quiet();
    step(); imemREN = 1'b0; imemaddr = 32'h40; iwait = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      vectors++;
      if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0 || iaddr !== 32'h0) begin
        miscompares++;
        $display("FAIL idle_quiet: ihit=%b imemload=%h iREN=%b iaddr=%h, want all 0", ihit, imemload, iREN, iaddr);
      end
      step();
    end
    iwait = 1'b1;
  endtask

  task automatic test_conflict();
    step(); do_fetch(32'h80, 1);
    step(); do_fetch(32'h40, 2);
  endtask

  task automatic test_addr_change();
    step(); do_fetch(32'h80, 0);
    step(); imemREN = 1'b1; imemaddr = 32'h40;
    @(negedge CLK);
    step(); imemaddr = 32'h44; iwait = 1'b1;
    @(negedge CLK);
    vectors++;
    if (iREN !== 1'b1 || iaddr !== 32'h40) begin
      miscompares++;
      $display("FAIL chg_hold: iREN=%b iaddr=%h, want 1/00000040", iREN, iaddr);
    end
    step(); iwait = 1'b0; iload = mem_word(32'h40);
    @(negedge CLK);
    vectors++;
    if (iaddr !== 32'h40) begin
      miscompares++;
      $display("FAIL chg_fill_addr: iaddr=%h, want 00000040", iaddr);
    end
    mvalid[0] = 1'b1; mtag[0] = 26'h1;
    step(); iwait = 1'b1;
    exp_q.push_back(mem_word(32'h44));
    @(negedge CLK);
    vectors++;
    if (ihit !== 1'b0 || iREN !== 1'b0) begin
      miscompares++;
      $display("FAIL chg_new_miss: ihit=%b iREN=%b, want 0/0", ihit, iREN);
    end
    step(); iwait = 1'b0; iload = mem_word(32'h44);
    @(negedge CLK);
    vectors++;
    if (iREN !== 1'b1 || iaddr !== 32'h44) begin
      miscompares++;
      $display("FAIL chg_second_req: iREN=%b iaddr=%h, want 1/00000044", iREN, iaddr);
    end
    step(); iwait = 1'b1;
    @(negedge CLK);
    begin
      logic [31:0] exp;
      exp = exp_q.pop_front();
      vectors++;
      if (ihit !== 1'b1 || imemload !== exp) begin
        miscompares++;
        $display("FAIL chg_second_hit: ihit=%b imemload=%h, want 1/%h", ihit, imemload, exp);
      end
    end
    mvalid[1] = 1'b1; mtag[1] = 26'h1;
    step(); do_fetch(32'h40, 0);
  endtask

  task automatic test_reset_mid_fetch();
    step(); do_fetch(32'h80, 0);
    step(); imemREN = 1'b1; imemaddr = 32'h40;
    @(negedge CLK);
    step(); iwait = 1'b1;
    @(negedge CLK);
    vectors++;
    if (iREN !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_fetch: iREN=%b, want 1", iREN);
    end
    step(); RST = 1'b1; iwait = 1'b0; iload = 32'h0BAD_0BAD; imemREN = 1'b0;
    step(); RST = 1'b0; iwait = 1'b1;
    model_clear();
    @(negedge CLK);
    vectors++;
    if (iREN !== 1'b0 || iaddr !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_abandon: iREN=%b iaddr=%h, want 0/0", iREN, iaddr);
    end
    step(); do_fetch(32'h40, 1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] tbl [6];
    tbl[0] = 32'h40;  tbl[1] = 32'h44; tbl[2] = 32'h80;
    tbl[3] = 32'h100; tbl[4] = 32'h48; tbl[5] = 32'h3C0;
    for (int n = 0; n < 24; n++) begin
      step();
      do_fetch(tbl[$urandom_range(0, 5)], int'($urandom_range(0, 2)));
    end
    step(); imemREN = 1'b0;
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_cold_miss();
    test_repeat_hit();
    test_stats();
    test_idle_quiet();
    test_conflict();
    test_addr_change();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
